// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter.
// The arbiter connects through the slave modport; the CPU/memory side uses master.
interface mem_arbiter_if #(
    parameter int N = 32
);
    // Instruction-fetch port
    logic         IReq;
    logic [N-1:0] IAddr;
    logic [N-1:0] IRData;
    logic         IReady;
    // Data (load/store) port
    logic         DReq;
    logic         DWrite;
    logic [N-1:0] DAddr;
    logic [N-1:0] DWData;
    logic [N-1:0] DRData;
    logic         DReady;
    // Memory side
    logic         MemReq;
    logic         MemWe;
    logic [N-1:0] MemAddr;
    logic [N-1:0] MemWData;
    logic [N-1:0] MemRData;
    logic         MemAck;
    // Status
    logic         StallF;
    logic         StallM;
    logic         ErrorFlag;

    modport slave (
        input  IReq, IAddr, DReq, DWrite, DAddr, DWData, MemRData, MemAck,
        output IRData, IReady, DRData, DReady,
        output MemReq, MemWe, MemAddr, MemWData,
        output StallF, StallM, ErrorFlag
    );

    modport master (
        output IReq, IAddr, DReq, DWrite, DAddr, DWData, MemRData, MemAck,
        input  IRData, IReady, DRData, DReady,
        input  MemReq, MemWe, MemAddr, MemWData,
        input  StallF, StallM, ErrorFlag
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter onto a single memory bus.
// Data has priority, but after MAXD consecutive data grants with a waiting
// fetch the instruction port wins once. A per-transfer timeout aborts a
// transfer the memory never acknowledges and sets a sticky error flag.
module mem_arbiter #(
    parameter int N       = 32,
    parameter int TIMEOUT = 255,
    parameter int MAXD    = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] MAXD_C   = 4'(MAXD);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    state_t       state_q,     state_d;
    logic         mem_req_q,   mem_req_d;
    logic         mem_we_q,    mem_we_d;
    logic [N-1:0] mem_addr_q,  mem_addr_d;
    logic [N-1:0] mem_wdata_q, mem_wdata_d;
    logic [N-1:0] i_rdata_q,   i_rdata_d;
    logic [N-1:0] d_rdata_q,   d_rdata_d;
    logic         i_ready_q,   i_ready_d;
    logic         d_ready_q,   d_ready_d;
    logic [3:0]   streak_q,    streak_d;
    logic [9:0]   tmo_q,       tmo_d;
    logic         err_q,       err_d;

    logic         i_elig_s;
    logic         d_elig_s;
    logic         settle_s;

    // A port is not eligible in its own Ready cycle. Arbitration is also held
    // off for that whole cycle so the finishing requester can present its next
    // request and compete fairly against a waiting fetch on the following edge.
    assign i_elig_s = bus.IReq & ~i_ready_q;
    assign d_elig_s = bus.DReq & ~d_ready_q;
    assign settle_s = i_ready_q | d_ready_q;

    // Next-state, grant, completion and timeout logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (!bus.IReq) begin
                    streak_d = 4'd0;
                end else begin
                    streak_d = streak_q;
                end

                if (settle_s) begin
                    state_d = IDLE;
                end else if (d_elig_s && !(i_elig_s && (streak_q == MAXD_C))) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.DWrite;
                    mem_addr_d  = bus.DAddr;
                    mem_wdata_d = bus.DWData;
                    tmo_d       = 10'd0;
                    if (bus.IReq && (streak_q != MAXD_C)) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = bus.IReq ? streak_q : 4'd0;
                    end
                end else if (i_elig_s) begin
                    state_d     = IBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.IAddr;
                    mem_wdata_d = {N{1'b0}};
                    tmo_d       = 10'd0;
                    streak_d    = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            IBUSY, DBUSY: begin
                if (bus.MemAck) begin
                    // Acknowledge wins even on the cycle the timeout would fire
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == IBUSY) begin
                        i_rdata_d = bus.MemRData;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_we_q ? {N{1'b0}} : bus.MemRData;
                        d_ready_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Give up: complete the owner with zero data and flag it
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_d     = tmo_q + 10'd1;
                    err_d     = 1'b1;
                    if (state_q == IBUSY) begin
                        i_rdata_d = {N{1'b0}};
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = {N{1'b0}};
                        d_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {N{1'b0}};
            mem_wdata_q <= {N{1'b0}};
            i_rdata_q   <= {N{1'b0}};
            d_rdata_q   <= {N{1'b0}};
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            streak_q    <= 4'd0;
            tmo_q       <= 10'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    assign bus.MemReq    = mem_req_q;
    assign bus.MemWe     = mem_we_q;
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemWData  = mem_wdata_q;
    assign bus.IRData    = i_rdata_q;
    assign bus.DRData    = d_rdata_q;
    assign bus.IReady    = i_ready_q;
    assign bus.DReady    = d_ready_q;
    assign bus.ErrorFlag = err_q;
    assign bus.StallF    = bus.IReq & ~i_ready_q;
    assign bus.StallM    = bus.DReq & ~d_ready_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: address and data width of all buses.
REQ-002 Parameter TIMEOUT, default 255: maximum busy cycles waiting for MemAck; range 1..1023.
REQ-003 Parameter MAXD, default 4: maximum consecutive data grants while an instruction request waits; range 1..15.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low; 0 = reset.
REQ-006 IReq  in  1  instruction-fetch request.
REQ-007 IAddr  in  N  fetch address.
REQ-008 IRData  out  N  fetched word.
REQ-009 IReady  out  1  one-cycle completion pulse for fetch.
REQ-010 DReq  in  1  data (LDR/STR) request.
REQ-011 DWrite  in  1  1 = store, 0 = load.
REQ-012 DAddr  in  N  data address.
REQ-013 DWData  in  N  store data.
REQ-014 DRData  out  N  load data.
REQ-015 DReady  out  1  one-cycle completion pulse for data.
REQ-016 MemReq  out  1  memory request, registered.
REQ-017 MemWe  out  1  memory write enable, registered.
REQ-018 MemAddr  out  N  memory address, registered.
REQ-019 MemWData  out  N  memory write data, registered.
REQ-020 MemRData  in  N  memory read data, valid when MemAck = 1.
REQ-021 MemAck  in  1  memory completion, sampled while MemReq = 1.
REQ-022 StallF  out  1  combinational: IReq & ~IReady.
REQ-023 StallM  out  1  combinational: DReq & ~DReady.
REQ-024 ErrorFlag  out  1  sticky timeout indicator.

Function
REQ-025 FSM states: IDLE, IBUSY, DBUSY.
REQ-026 In IDLE, an eligible request causes a grant that edge: MemReq = 1, MemAddr/MemWe/MemWData loaded from the granted port, and the state moves to IBUSY or DBUSY.
REQ-027 A port's request is ineligible in the cycle its Ready output is 1. Consequence: a Ready cycle never triggers a re-grant of the same transfer.
REQ-028 Priority when both are eligible: data wins, unless the streak counter equals MAXD, in which case instruction wins.
REQ-029 Streak counter (4 bits):
- increments on each data grant made while IReq = 1;
- clears on any instruction grant, or whenever IReq = 0 in IDLE;
- saturates at MAXD.
REQ-030 Instruction grants always drive MemWe = 0 and MemWData = 0.
REQ-031 In a BUSY state, MemReq, MemWe, MemAddr and MemWData hold stable regardless of requester inputs.
REQ-032 In a BUSY state with MemAck = 1:
- MemRData is registered into IRData or DRData; for a store, DRData is loaded with 0;
- next cycle: the matching Ready = 1 for exactly one cycle, MemReq = 0, state = IDLE.
REQ-033 Minimum latency, with MemAck returned in the first MemReq cycle: request at cycle 0, MemReq at cycle 1, Ready at cycle 2.
REQ-034 Timeout counter:
- clears on grant;
- increments each BUSY cycle with MemAck = 0;
- when it reaches TIMEOUT: drop MemReq, return to IDLE, pulse the owning port's Ready next cycle with RData = 0, and set ErrorFlag.
REQ-035 If MemAck arrives in the same cycle the counter reaches TIMEOUT, MemAck wins: normal completion, ErrorFlag unchanged.
REQ-036 IRData and DRData hold their last value until the next completion on that port.
REQ-037 A requester dropping Req while its transfer is BUSY does not abort the transfer; completion still pulses Ready.
REQ-038 The requester holds Req, address and data stable until Ready; the arbiter captures these only at grant.

Reset
REQ-039 Reset = 0 forces immediately, independent of CLK:
- state = IDLE;
- MemReq = MemWe = 0; MemAddr = MemWData = 0;
- IRData = DRData = 0; IReady = DReady = 0;
- streak counter = 0, timeout counter = 0, ErrorFlag = 0.
REQ-040 Reset asserted mid-transfer abandons the transfer; no Ready pulse is produced after reset release.
REQ-041 The first grant is possible on the first rising edge after Reset returns to 1.

Verification
REQ-042 Bench covers: IReq = 1, IAddr = 0x10, IDLE; MemAck = 1 with MemRData = 0xE3A01005 at first MemReq cycle -> IReady pulse at cycle 2, IRData = 0xE3A01005, MemWe = 0 throughout.
REQ-043 Bench covers: IReq = DReq = 1, DWrite = 1, DAddr = 0x40, DWData = 0xAA -> data granted first with MemWe = 1, MemAddr = 0x40, MemWData = 0xAA; instruction granted after DReady.
REQ-044 Bench covers: IReq held, 5 back-to-back data requests, MAXD = 4 -> grant order D, D, D, D, I, D.
REQ-045 Bench covers: TIMEOUT = 8, MemAck held 0 -> MemReq drops after 8 busy cycles, DReady pulses with DRData = 0, ErrorFlag = 1 until reset.
REQ-046 Bench covers: Reset = 0 asserted asynchronously between edges while in DBUSY -> MemReq = 0 immediately; after release no DReady pulse, state IDLE.
REQ-047 Bench covers: MemAck = 1 on the exact cycle the timeout counter reaches TIMEOUT -> normal completion with MemRData, ErrorFlag stays 0.
